mem_arbiter_2x: RTL

MEM_ARBITER_2X -- requirements
Module: mem_arbiter_2x

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_bank.sv | 25 ++
 rtl/mem_arbiter_2x.sv | 102 ++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, size defaults and direction constants for the two-port memory arbiter
package mem_arb_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;
   localparam int   WIDTH_DEF = 4;
   localparam int   DEPTH_DEF = 4;
   localparam logic RW_WRITE  = 1'b1;
   localparam logic RW_READ   = 1'b0;
endpackage

// File: rtl/mem_bank.sv
// mem_bank: DEPTH x WIDTH storage with synchronous write, combinational read and async clear
module mem_bank
   import mem_arb_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   // clear every word on reset, otherwise commit the write on the clock edge
   always_ff @(posedge clk or negedge reset)
      if (!reset)
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      else if (we)
         mem[addr] <= wdata;

   assign rdata = mem[addr];
endmodule

// File: rtl/mem_arbiter_2x.sv
// mem_arbiter_2x: round-robin arbiter giving two requesters 4-cycle access to a private memory bank
module mem_arbiter_2x
   import mem_arb_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     a_req,
   input  logic                     a_rw,
   input  logic [$clog2(DEPTH)-1:0] a_addr,
   input  logic [WIDTH-1:0]         a_wdata,
   output logic                     a_gnt,
   output logic                     a_done,
   output logic [WIDTH-1:0]         a_rdata,
   input  logic                     b_req,
   input  logic                     b_rw,
   input  logic [$clog2(DEPTH)-1:0] b_addr,
   input  logic [WIDTH-1:0]         b_wdata,
   output logic                     b_gnt,
   output logic                     b_done,
   output logic [WIDTH-1:0]         b_rdata,
   output logic                     busy
);
   localparam int AW = $clog2(DEPTH);

   state_t           state, state_nx;
   logic             last_b;
   logic             sel_b;
   logic             rw_q;
   logic [AW-1:0]    addr_q;
   logic [WIDTH-1:0] wdata_q;
   logic [WIDTH-1:0] mem_rdata;
   logic             pick_b;
   logic             start;
   logic             commit;

   // B wins when it is the only requester, or on a tie when A was served last
   assign pick_b = b_req & (~a_req | ~last_b);
   assign start  = (state == IDLE) & (a_req | b_req);
   assign commit = state == ACCESS;
   assign busy   = state != IDLE;

   // state register
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else        state <= state_nx;

   // only IDLE waits for a request; the remaining phases advance every cycle
   always_comb begin
      state_nx = IDLE;
      state_nx = state == IDLE   ? (start ? SETUP : IDLE) :
                 state == SETUP  ? ACCESS :
                 state == ACCESS ? RESP : IDLE;
   end

   // latch the winner's request, drive grants/done and capture read data
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         last_b  <= 1'b1;
         sel_b   <= 1'b0;
         rw_q    <= RW_READ;
         addr_q  <= '0;
         wdata_q <= '0;
         a_gnt   <= 1'b0;
         b_gnt   <= 1'b0;
         a_done  <= 1'b0;
         b_done  <= 1'b0;
         a_rdata <= '0;
         b_rdata <= '0;
      end else begin
         if (start) begin
            sel_b   <= pick_b;
            rw_q    <= pick_b ? b_rw : a_rw;
            addr_q  <= pick_b ? b_addr : a_addr;
            wdata_q <= pick_b ? b_wdata : a_wdata;
            a_gnt   <= ~pick_b;
            b_gnt   <= pick_b;
         end
         if (state == RESP) begin
            a_gnt <= 1'b0;
            b_gnt <= 1'b0;
         end
         a_done <= commit & ~sel_b;
         b_done <= commit & sel_b;
         if (commit) begin
            last_b <= sel_b;
            if (rw_q == RW_READ && !sel_b) a_rdata <= mem_rdata;
            if (rw_q == RW_READ && sel_b)  b_rdata <= mem_rdata;
         end
      end

   mem_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank (
      .clk   (clk),
      .reset (reset),
      .we    (commit & (rw_q == RW_WRITE)),
      .addr  (addr_q),
      .wdata (wdata_q),
      .rdata (mem_rdata)
   );
endmodule
